alu_wb_buffer: RTL
==================

# alu_wb_buffer

Writeback buffer directly downstream of the ALU functional unit. It captures each ALU result (`result_o`, `alu_branch_res_o`) with its transaction ID into a small FIFO and presents the entries in order on a valid/ready writeback port to the scoreboard. This decouples the single-cycle ALU from writeback-port arbitration stalls. It also discards all speculative results on a pipeline flush.

## Interface
- `DEPTH`, default 4: number of entries. Power of two, minimum 2.
- `TRANS_ID_BITS`, default `ariane_pkg::TRANS_ID_BITS`: width of the scoreboard transaction ID.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `flush_i`  in  1  synchronous flush; drops all held entries.
- `alu_valid_i`  in  1  ALU result valid this cycle.
- `alu_ready_o`  out  1  buffer can accept a result this cycle.
- `alu_trans_id_i`  in  TRANS_ID_BITS  transaction ID of the result.
- `alu_result_i`  in  64  ALU `result_o`.
- `alu_branch_res_i`  in  1  ALU `alu_branch_res_o`.
- `alu_is_branch_i`  in  1  operator was one of EQ/NE/LTS/LTU/GES/GEU.
- `wb_valid_o`  out  1  head entry is valid.
- `wb_ready_i`  in  1  writeback port accepts the head entry.
- `wb_trans_id_o`  out  TRANS_ID_BITS  head transaction ID.
- `wb_result_o`  out  64  head result.
- `wb_branch_res_o`  out  1  head branch outcome.
- `wb_is_branch_o`  out  1  head entry came from a branch compare.
- `usage_o`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage is a circular FIFO with a read pointer, a write pointer (each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0) and an occupancy counter.
- Push occurs when `alu_valid_i && alu_ready_o`.
  - The entry is written at the write pointer; the write pointer increments.
- Pop occurs when `wb_valid_o && wb_ready_i`.
  - The read pointer increments.
- `alu_ready_o = (usage_o != DEPTH)`.
  - It is a function of the registered count only; there is no combinational path from `wb_ready_i`.
  - When full, no push is accepted even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full, not empty): occupancy is unchanged and both pointers advance.
- Push with `alu_ready_o=0` is a protocol violation by the upstream stage. The buffer ignores it: no state change.
- `wb_valid_o = (usage_o != 0)`.
  - The head fields come straight from storage at the read pointer.
  - When `wb_valid_o=0`, all `wb_*` data outputs are driven to 0.
- Ordering is strictly FIFO; entries are never reordered or merged.
- Non-branch entries carry whatever `alu_branch_res_i` value arrived with them.
- Flush has priority over push and pop in the same cycle:
  - pointers and count are cleared;
  - any push in that cycle is dropped;
  - any pop in that cycle is not counted as a completed writeback; the consumer must also flush.
- Reset: identical effect to flush, plus the storage contents are cleared to 0.

## Timing
- Latency: a push at edge T makes the entry visible at head (`wb_valid_o=1`) after T, in cycle T+1, if the buffer was empty. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle in steady state.
- Once `wb_valid_o` is asserted, the head data is stable until the pop edge or a flush/reset.
- Values after a reset edge:
  - `alu_ready_o=1`;
  - `wb_valid_o=0`;
  - `wb_trans_id_o=0`, `wb_result_o=0`, `wb_branch_res_o=0`, `wb_is_branch_o=0`;
  - `usage_o=0`.
- Reset asserted mid-operation takes effect at the next edge regardless of the handshake state; in-flight entries are lost.
- Flush: `usage_o=0` and `wb_valid_o=0` in the cycle after the flush edge; `alu_ready_o=1` in the same cycle.

## Structure
- `ariane_pkg` gains the typedef `alu_wb_entry_t` with fields:
  - `trans_id` [TRANS_ID_BITS-1:0];
  - `result` [63:0];
  - `branch_res`;
  - `is_branch`.
- The storage array uses `alu_wb_entry_t` internally.
- One sub-module is natural: `alu_wb_fifo`, a generic pointer/count FIFO parameterised on DEPTH and the entry type.
- `alu_wb_buffer` wraps `alu_wb_fifo` with the flush priority and the output zeroing.

## Test plan
- **Reset, then a single push.** Stimulus: `rst_i` for 2 cycles, then push id=3, result=64'h0000_0000_DEAD_BEEF, branch_res=0, is_branch=0, with `wb_ready_i=1`. Required: `wb_valid_o=0` in the push cycle; the next cycle shows `wb_valid_o=1`, id=3, result=64'hDEADBEEF; then `usage_o` returns to 0.
- **Fill and wrap (DEPTH=4).** Stimulus: `wb_ready_i=0`, push ids 0,1,2,3. Required: `alu_ready_o=0` and `usage_o=4`; a fifth push is ignored. Then `wb_ready_i=1` for 6 cycles while pushing ids 4,5. Required: pops arrive in order 0,1,2,3,4,5 with pointer wrap and no loss.
- **Simultaneous push and pop at usage 2.** Required: `usage_o` stays 2, and head order is preserved across 10 back-to-back cycles (ids 0..9 in order).
- **Branch entry.** Stimulus: push is_branch=1, branch_res=1, result=0. Required: `wb_is_branch_o=1`, `wb_branch_res_o=1`, `wb_result_o=0`.
- **Flush with concurrent push and pop at usage 3.** Required: next cycle `usage_o=0`, `wb_valid_o=0`, all `wb_*` data outputs 0, `alu_ready_o=1`; the pushed entry never appears.
- **Reset mid-stall.** Stimulus: usage 4, `wb_ready_i=0`, assert `rst_i` for 1 cycle. Required: all outputs at their reset values on the next cycle, and a following push emerges normally one cycle later.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared core definitions used by the ALU writeback buffer.
package ariane_pkg;

    // The scoreboard holds 16 entries, so a transaction ID is 4 bits wide.
    localparam int unsigned NR_SB_ENTRIES = 16;
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

    // One buffered ALU result waiting for a writeback slot.
    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [63:0]              result;
        logic                     branch_res;
        logic                     is_branch;
    } alu_wb_entry_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// Generic circular FIFO with read/write pointers and an occupancy counter.
// Clear drops all entries without touching storage; reset also zeroes storage.
module alu_wb_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  entry_t                   data_i,
    input  logic                     pop_i,
    output entry_t                   data_o,
    output logic [$clog2(DEPTH):0]   usage_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    entry_t           r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Qualify requests: a full FIFO refuses pushes, an empty one refuses pops, clear blocks both.
    always_comb begin
        w_full  = (r_count == CNT_W'(DEPTH));
        w_empty = (r_count == CNT_W'(0));
        w_push  = push_i && !w_full  && !clr_i;
        w_pop   = pop_i  && !w_empty && !clr_i;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_rd_ptr <= PTR_W'(0);
            r_wr_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: zeroed on reset, written at the write pointer on an accepted push.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign usage_o = r_count;

endmodule

// File: rtl/alu_wb_buffer.sv
// Writeback buffer behind the ALU: queues results in order and offers them
// to the scoreboard on a valid/ready port. Flush discards everything held.
module alu_wb_buffer
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     alu_valid_i,
    output logic                     alu_ready_o,
    input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
    input  logic [63:0]              alu_result_i,
    input  logic                     alu_branch_res_i,
    input  logic                     alu_is_branch_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [63:0]              wb_result_o,
    output logic                     wb_branch_res_o,
    output logic                     wb_is_branch_o,
    output logic [$clog2(DEPTH):0]   usage_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    alu_wb_entry_t    w_in_entry;
    alu_wb_entry_t    w_head;
    logic [CNT_W-1:0] w_usage;

    // Pack the incoming ALU result into a buffer entry.
    always_comb begin
        w_in_entry            = '0;
        w_in_entry.trans_id   = alu_trans_id_i;
        w_in_entry.result     = alu_result_i;
        w_in_entry.branch_res = alu_branch_res_i;
        w_in_entry.is_branch  = alu_is_branch_i;
    end

    // The FIFO gates push on full and pop on empty; flush acts as its clear.
    alu_wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (alu_wb_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (flush_i),
        .push_i  (alu_valid_i),
        .data_i  (w_in_entry),
        .pop_i   (wb_ready_i),
        .data_o  (w_head),
        .usage_o (w_usage)
    );

    // Handshake flags depend only on the registered count, so ready never sees wb_ready_i.
    always_comb begin
        alu_ready_o = (w_usage != CNT_W'(DEPTH));
        wb_valid_o  = (w_usage != CNT_W'(0));
        usage_o     = w_usage;
    end

    // Present the head entry, or all zeros when nothing is held.
    always_comb begin
        if (wb_valid_o) begin
            wb_trans_id_o   = w_head.trans_id;
            wb_result_o     = w_head.result;
            wb_branch_res_o = w_head.branch_res;
            wb_is_branch_o  = w_head.is_branch;
        end else begin
            wb_trans_id_o   = '0;
            wb_result_o     = 64'd0;
            wb_branch_res_o = 1'b0;
            wb_is_branch_o  = 1'b0;
        end
    end

endmodule
